// File: rtl/instruction_memory_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Byte ordering matches the fetch side: the most-significant byte goes to the lowest address.
package instruction_memory_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_WRITE  = 2'd2,
      ST_DONE   = 2'd3
   } loader_state_e;

   localparam int BYTES_PER_INSTR = 4;
   localparam bit MSB_AT_LOW_ADDR = 1'b1;

   function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] idx);
      logic [1:0] lane;
      lane = MSB_AT_LOW_ADDR ? (2'd3 - idx) : idx;
      case (lane)
         2'd0:    lane_byte = word[7:0];
         2'd1:    lane_byte = word[15:8];
         2'd2:    lane_byte = word[23:16];
         default: lane_byte = word[31:24];
      endcase
   endfunction

endpackage

// File: rtl/instruction_memory_loader_serializer.sv
// Holds one captured instruction word and walks it out a byte at a time.
// idx counts byte slots; lane selection comes from the shared ordering helper.
module imem_byte_serializer
   import instruction_memory_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        advance,
   input  logic [31:0] word_in,
   output logic [1:0]  idx,
   output logic [7:0]  byte_out,
   output logic        last_byte
);

   logic [31:0] word_q, word_d;
   logic [1:0]  idx_q, idx_d;

   always_comb begin
      word_d = word_q;
      idx_d  = idx_q;
      if (load) begin
         word_d = word_in;
         idx_d  = '0;
      end else if (advance) begin
         idx_d = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_q <= '0;
         idx_q  <= '0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end

   assign idx       = idx_q;
   assign byte_out  = lane_byte(word_q, idx_q);
   assign last_byte = (idx_q == 2'(BYTES_PER_INSTR - 1));

endmodule

// File: rtl/instruction_memory_loader.sv
// Streams 32-bit instruction words into a byte-wide memory port, four writes per word.
// state     | meaning
// ST_IDLE   | waiting for start
// ST_ACCEPT | instr_ready high, waiting for a word
// ST_WRITE  | emitting the four bytes of the captured word
// ST_DONE   | one-cycle done pulse, then back to idle
module instruction_memory_loader
   import instruction_memory_loader_pkg::*;
#(
   parameter int MEM_BYTES = 64,
   parameter int ADDR_W    = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       instr_data,
   input  logic              instr_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              overflow_err,
   output logic [15:0]       words_written
);

   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

   loader_state_e     state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [15:0]       words_q, words_d;
   logic              ovf_q, ovf_d;
   logic              last_q, last_d;

   logic       ser_load, ser_adv, ser_last_byte, word_fits;
   logic [1:0] ser_idx;
   logic [7:0] ser_byte;

   // One bit wider than the pointer so a pointer near the top of the address space cannot wrap.
   assign word_fits = ({1'b0, wr_ptr_q} + (ADDR_W+1)'(3)) < MEM_LIMIT;

   imem_byte_serializer u_serializer (
      .clk       (clk),
      .reset     (reset),
      .load      (ser_load),
      .advance   (ser_adv),
      .word_in   (instr_data),
      .idx       (ser_idx),
      .byte_out  (ser_byte),
      .last_byte (ser_last_byte)
   );

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      words_d     = words_q;
      ovf_d       = ovf_q;
      last_d      = last_q;
      ser_load    = 1'b0;
      ser_adv     = 1'b0;
      instr_ready = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      done        = 1'b0;
      busy        = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_ACCEPT;
               wr_ptr_d = base_addr;
               words_d  = '0;
               ovf_d    = 1'b0;
            end
         end
         ST_ACCEPT: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               if (word_fits) begin
                  ser_load = 1'b1;
                  last_d   = instr_last;
                  state_d  = ST_WRITE;
               end else begin
                  ovf_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_WRITE: begin
            mem_we    = 1'b1;
            mem_addr  = wr_ptr_q + ADDR_W'(ser_idx);
            mem_wdata = ser_byte;
            ser_adv   = 1'b1;
            if (ser_last_byte) begin
               wr_ptr_d = wr_ptr_q + ADDR_W'(BYTES_PER_INSTR);
               words_d  = (words_q == 16'hFFFF) ? words_q : words_q + 16'd1;
               state_d  = last_q ? ST_DONE : ST_ACCEPT;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         words_q  <= '0;
         ovf_q    <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         words_q  <= words_d;
         ovf_q    <= ovf_d;
         last_q   <= last_d;
      end
   end

   assign overflow_err  = ovf_q;
   assign words_written = words_q;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Bench for instruction_memory_loader: directed sessions plus randomized ones,
// checked every cycle against an event-scheduling reference model.
module tb_instruction_memory_loader;

   localparam int MEM_BYTES = 64;
   localparam int ADDR_W    = 64;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              instr_valid = 1'b0;
   logic              instr_ready;
   logic [31:0]       instr_data = '0;
   logic              instr_last = 1'b0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              busy;
   logic              done;
   logic              overflow_err;
   logic [15:0]       words_written;

   always #5 clk = ~clk;

   instruction_memory_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .base_addr     (base_addr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_data    (instr_data),
      .instr_last    (instr_last),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .busy          (busy),
      .done          (done),
      .overflow_err  (overflow_err),
      .words_written (words_written)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {int c; logic [63:0] a; logic [7:0] d;} wr_t;
   wr_t log_q[$];
   int  done_cnt = 0;
   int  ready_cnt = 0;
   logic [31:0] tx_words[$];

   // Reference model: expected values for the current cycle plus scheduled future events.
   bit          m_ready = 0, m_busy = 0, m_ovf = 0;
   logic [15:0] m_words = '0;
   logic [63:0] m_ptr = '0;
   int          w0 = -100;
   int          done_cyc = -100;
   logic [63:0] w_addr = '0;
   logic [31:0] w_data = '0;
   bit          w_last = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      bit          e_we, e_done;
      logic [63:0] e_addr;
      logic [7:0]  e_data;
      int          k;
      bit          n_ready, n_busy, n_ovf;
      logic [15:0] n_words;

      k      = cyc - w0;
      e_we   = (k >= 0) && (k <= 3);
      e_addr = '0;
      e_data = '0;
      if (e_we) begin
         e_addr = w_addr + 64'(k);
         e_data = 8'(w_data >> (8 * (3 - k)));
      end
      e_done = (cyc == done_cyc);

      if (cyc >= 1) begin
         chk("instr_ready",   instr_ready,   m_ready);
         chk("mem_we",        mem_we,        e_we);
         chk("mem_addr",      mem_addr,      e_addr);
         chk("mem_wdata",     mem_wdata,     e_data);
         chk("busy",          busy,          m_busy);
         chk("done",          done,          e_done);
         chk("overflow_err",  overflow_err,  m_ovf);
         chk("words_written", words_written, m_words);
      end
      if (mem_we) log_q.push_back('{cyc, mem_addr, mem_wdata});
      if (done) done_cnt++;
      if (instr_ready) ready_cnt++;

      if (reset) begin
         m_ready = 0; m_busy = 0; m_ovf = 0; m_words = '0; m_ptr = '0;
         w0 = -100; done_cyc = -100;
      end else begin
         n_ready = m_ready; n_busy = m_busy; n_ovf = m_ovf; n_words = m_words;
         if (!m_busy && start) begin
            n_busy = 1; n_ready = 1; m_ptr = base_addr; n_words = '0; n_ovf = 0;
         end
         if (e_we && k == 3) begin
            m_ptr   = m_ptr + 64'd4;
            n_words = (m_words == 16'hFFFF) ? m_words : m_words + 16'd1;
            if (w_last) done_cyc = cyc + 1;
            else        n_ready = 1;
         end
         if (m_ready && instr_valid) begin
            n_ready = 0;
            if (({1'b0, m_ptr} + 65'd4) <= 65'(MEM_BYTES)) begin
               w0 = cyc + 1; w_addr = m_ptr; w_data = instr_data; w_last = instr_last;
            end else begin
               n_ovf = 1; done_cyc = cyc + 1;
            end
         end
         if (e_done) n_busy = 0;
         m_ready = n_ready; m_busy = n_busy; m_ovf = n_ovf; m_words = n_words;
      end
      cyc++;
   end

   // Called at posedge+#1 with the DUT idle. stray: 0 none, 1 start on first write, 2 random.
   task automatic run_session(input logic [63:0] base, input int vpct, input int rst_write,
                              input int stray);
      int i, n, guard, wr_seen;
      bit hs, bsy, we, fin, stray_done;
      i = 0; n = tx_words.size(); guard = 0; wr_seen = 0; fin = 0; stray_done = 0;
      log_q.delete(); done_cnt = 0; ready_cnt = 0;
      start = 1; base_addr = base;
      @(posedge clk); #1;
      start = 0;
      while (!fin) begin
         if (i < n) begin
            instr_valid = ($urandom_range(99) < vpct);
            instr_data  = tx_words[i];
            instr_last  = (i == n - 1);
         end else begin
            instr_valid = 0;
         end
         @(negedge clk);
         hs = instr_ready && instr_valid; bsy = busy; we = mem_we;
         if (hs) i++;
         if (we) wr_seen++;
         @(posedge clk); #1;
         start = 0; reset = 0;
         if (!bsy) fin = 1;
         else if (we) begin
            if (wr_seen == rst_write) reset = 1;
            if ((stray == 1 && !stray_done) || (stray == 2 && $urandom_range(9) == 0)) begin
               start = 1; base_addr = 64'(4 * $urandom_range(0, 15));
               if (stray == 1) base_addr = 64'd32;
               stray_done = 1;
            end
         end
         guard++;
         if (guard > 300) begin
            checks++; errors++;
            $display("FAIL session_timeout: got %0d cycles, expected at most 300", guard);
            fin = 1;
         end
      end
      instr_valid = 0; start = 0; reset = 0;
   endtask

   logic [7:0] exp3[12] = '{8'hCB, 8'h03, 8'h00, 8'h4B, 8'h8B, 8'h04, 8'h00, 8'h6C,
                            8'hF8, 8'h43, 8'h00, 8'h2D};
   logic [7:0] exp1[4] = '{8'hF8, 8'h42, 8'h80, 8'h2A};
   logic [7:0] exp4[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

   initial begin
      reset = 1;
      repeat (3) @(posedge clk);
      #1 reset = 0;

      // Idle with valid held high and no start
      instr_valid = 1; log_q.delete(); ready_cnt = 0; done_cnt = 0;
      repeat (10) @(posedge clk);
      #1 instr_valid = 0;
      chk("idle_writes", log_q.size(), 0);
      chk("idle_ready",  ready_cnt, 0);

      // Single word at address 0
      tx_words = '{32'hF842802A};
      run_session(64'd0, 100, -1, 0);
      chk("single_nwr", log_q.size(), 4);
      if (log_q.size() == 4)
         for (int j = 0; j < 4; j++) begin
            chk("single_addr", log_q[j].a, 64'(j));
            chk("single_data", log_q[j].d, exp1[j]);
            chk("single_cyc",  log_q[j].c - log_q[0].c, j);
         end
      chk("single_done",  done_cnt, 1);
      chk("single_words", words_written, 1);

      // Back-to-back words from address 8
      tx_words = '{32'hCB03004B, 32'h8B04006C, 32'hF843002D};
      run_session(64'd8, 100, -1, 0);
      chk("b2b_nwr", log_q.size(), 12);
      if (log_q.size() == 12) begin
         for (int j = 0; j < 12; j++) begin
            chk("b2b_addr", log_q[j].a, 64'(8 + j));
            chk("b2b_data", log_q[j].d, exp3[j]);
         end
         chk("b2b_span", log_q[11].c - log_q[0].c, 13);
      end
      chk("b2b_ready", ready_cnt, 3);
      chk("b2b_words", words_written, 3);

      // Overflow at the top of memory
      tx_words = '{32'hDEADBEEF, 32'h01020304};
      run_session(64'd60, 100, -1, 0);
      chk("ovf_nwr", log_q.size(), 4);
      if (log_q.size() == 4)
         for (int j = 0; j < 4; j++) begin
            chk("ovf_addr", log_q[j].a, 64'(60 + j));
            chk("ovf_data", log_q[j].d, exp4[j]);
         end
      chk("ovf_flag",  overflow_err, 1);
      chk("ovf_done",  done_cnt, 1);
      chk("ovf_words", words_written, 1);

      // Reset during the idx=2 byte
      tx_words = '{32'hA1B2C3D4, 32'h55667788};
      run_session(64'd0, 100, 2, 0);
      chk("rst_nwr",   log_q.size(), 3);
      chk("rst_done",  done_cnt, 0);
      chk("rst_words", words_written, 0);
      chk("rst_we",    mem_we, 0);
      chk("rst_busy",  busy, 0);

      // Start pulsed during WRITE is ignored
      tx_words = '{32'h11223344, 32'h55667788};
      run_session(64'd16, 100, -1, 1);
      chk("stray_nwr", log_q.size(), 8);
      if (log_q.size() == 8) begin
         chk("stray_first", log_q[0].a, 64'd16);
         chk("stray_last",  log_q[7].a, 64'd23);
      end
      chk("stray_words", words_written, 2);

      // Randomized sessions
      for (int s = 0; s < 40; s++) begin
         int nw, rw;
         tx_words.delete();
         nw = $urandom_range(1, 6);
         for (int j = 0; j < nw; j++) tx_words.push_back($urandom);
         rw = ($urandom_range(7) == 0) ? $urandom_range(1, 8) : -1;
         run_session(64'(4 * $urandom_range(0, 15)), $urandom_range(30, 100), rw, 2);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_memory_loader.md
# instruction_memory_loader

Sequential writer for the byte-addressed instruction memory: accepts 32-bit instruction words over a valid/ready stream and writes each as four consecutive byte writes, most-significant byte at the lowest address. It sits between the test/boot source and the instruction memory's byte write port, filling program memory before the CPU fetches from it. It counts words written, reports completion, and rejects words that would run past the end of memory.

## Interface
Parameters:
- MEM_BYTES, 64, instruction memory depth in bytes; must be a multiple of 4.
- ADDR_W, 64, byte address width, matching the program counter width.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a load session at base_addr; ignored unless in IDLE.
- base_addr  in  ADDR_W  first byte address; sampled on start; must be 4-byte aligned.
- instr_valid  in  1  source has a word on instr_data.
- instr_ready  out  1  loader accepts a word this cycle.
- instr_data  in  32  instruction word.
- instr_last  in  1  qualifies the accepted word as the final word of the session.
- mem_we  out  1  byte write strobe to instruction memory.
- mem_addr  out  ADDR_W  byte address of the write.
- mem_wdata  out  8  byte to write.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a session.
- overflow_err  out  1  sticky; set when a word is rejected for running past MEM_BYTES; cleared by reset or start.
- words_written  out  16  words fully written in the current session; cleared by start.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: start=1 moves to ACCEPT. In the same cycle, wr_ptr loads base_addr, words_written clears, and overflow_err clears.
- ACCEPT: instr_ready=1. A handshake occurs when instr_valid and instr_ready are both high at a clock edge.
  - If wr_ptr+3 < MEM_BYTES: capture instr_data into the shift register, latch instr_last, set byte index to 0, and go to WRITE.
  - Otherwise: drop the word, set overflow_err, and go to DONE.
- WRITE: mem_we=1, mem_addr = wr_ptr + idx, mem_wdata = the byte selected by idx, in the order [31:24], [23:16], [15:8], [7:0] for idx 0 to 3.
  - Writes are combinational from state and idx.
  - On the idx=3 edge: wr_ptr += 4 and words_written += 1 (saturates at 16'hFFFF). Then go to DONE if the latched last flag is set, else to ACCEPT.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- instr_valid outside ACCEPT is ignored and no data is consumed.
- mem_we=0 in every state except WRITE.
- Arithmetic: wr_ptr is ADDR_W-bit unsigned. The overflow check uses wr_ptr+3 computed at ADDR_W+1 bits, so the sum cannot wrap.
- Unaligned base_addr is not checked. Bytes are written at base_addr+k as given.

## Timing
- Reset values: state IDLE, instr_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, overflow_err 0, words_written 0, wr_ptr 0.
- Reset asserted mid-session: at the next edge all registers return to reset values. A partially written word stays partially written, and no done pulse is produced.
- Start at edge E: ACCEPT from E+1, so instr_ready is high in cycle E+1.
- Word accepted at edge N: byte writes occur in cycles N+1 through N+4, one per cycle, at consecutive addresses.
  - instr_ready is high again in cycle N+5. Sustained throughput is 1 word per 5 cycles.
  - If the word carried instr_last, done is high in cycle N+5 and busy drops in cycle N+6.
- Overflow rejection at edge N: done is high in cycle N+1. overflow_err is high from N+1 until the next start or reset.
- words_written increments on the idx=3 edge and is visible in the cycle after the last byte write.

## Structure
- Shared package holds:
  - the state enum (IDLE, ACCEPT, WRITE, DONE), encoded in 2 bits;
  - the constant BYTES_PER_INSTR = 4;
  - the byte-lane ordering constant: MSB at the lowest address, matching the fetch side.
- One sub-module is natural: imem_byte_serializer. It holds the 32-bit shift register, the 2-bit index and the lane selection. The top level keeps the FSM, wr_ptr, the counters and the overflow check.

## Test plan
- Reset then idle: hold instr_valid=1 with no start. Required: instr_ready=0, mem_we=0 and all outputs 0 for 10 cycles.
- Single word: start, base_addr=0, word 32'hF842802A with last=1. Required: writes F8@0, 42@1, 80@2, 2A@3 in four consecutive cycles; done one cycle later; words_written=1.
- Back-to-back words: three words 32'hCB03004B, 32'h8B04006C, 32'hF843002D with valid held high, base_addr=8. Required: 12 writes at addresses 8–19 in MSB-first order; instr_ready is high 1 cycle of every 5.
- Overflow: base_addr=60, two words with last on the second. Required: first word written at 60–63; second word dropped with no mem_we; overflow_err=1; done pulses; words_written=1.
- Reset mid-write: assert reset during the idx=2 byte. Required: mem_we=0 from the next cycle, state IDLE, no done pulse, words_written=0.
- Start ignored while busy: pulse start with base_addr=32 during WRITE. Required: wr_ptr and words_written are unaffected and the session continues at its original address.
